// File: rtl/cart_slot_buffer.sv
// Ordered 12-slot cart list fed by edge-detected add/undo/checkout/done requests.
// Registered list, count, flags and checkout lock for the display and payment paths.
module cart_slot_buffer #(
  parameter int MAX_ITEMS = 12,
  parameter int ID_W      = 4
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      add_req,
  input  logic [ID_W-1:0]           add_id,
  input  logic                      undo_req,
  input  logic                      checkout_req,
  input  logic                      done_req,
  output logic [MAX_ITEMS*ID_W-1:0] product_IDS,
  output logic [3:0]                item_count,
  output logic                      empty,
  output logic                      full,
  output logic                      locked,
  output logic                      reject
);

  typedef enum logic {SHOP = 1'b0, CHECKOUT = 1'b1} state_t;

  state_t r_state, w_nxt_state;

  // Index 0 is the leftmost (oldest) slot on the packed bus.
  logic [0:MAX_ITEMS-1][ID_W-1:0] r_slots, w_nxt_slots;
  logic [3:0] r_cnt, w_nxt_cnt;
  logic       r_empty, r_full, r_rej, w_rej;
  logic       r_add_q, r_undo_q, r_chk_q, r_done_q;
  logic       w_add_ev, w_undo_ev, w_chk_ev, w_done_ev;
  logic       w_is_empty, w_is_full;

  assign w_add_ev   = add_req      & ~r_add_q;
  assign w_undo_ev  = undo_req     & ~r_undo_q;
  assign w_chk_ev   = checkout_req & ~r_chk_q;
  assign w_done_ev  = done_req     & ~r_done_q;
  assign w_is_empty = (r_cnt == 4'd0);
  assign w_is_full  = (r_cnt == 4'(MAX_ITEMS));

  // State register plus all registered datapath state.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state  <= SHOP;
      r_slots  <= '0;
      r_cnt    <= 4'd0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_rej    <= 1'b0;
      r_add_q  <= 1'b0;
      r_undo_q <= 1'b0;
      r_chk_q  <= 1'b0;
      r_done_q <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_slots  <= w_nxt_slots;
      r_cnt    <= w_nxt_cnt;
      r_empty  <= (w_nxt_cnt == 4'd0);
      r_full   <= (w_nxt_cnt == 4'(MAX_ITEMS));
      r_rej    <= w_rej;
      r_add_q  <= add_req;
      r_undo_q <= undo_req;
      r_chk_q  <= checkout_req;
      r_done_q <= done_req;
    end
  end

  // Next state; priority done > checkout > undo > add.
  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      SHOP:     if (!w_done_ev && w_chk_ev && !w_is_empty) w_nxt_state = CHECKOUT;
      CHECKOUT: if (w_done_ev) w_nxt_state = SHOP;
      default:  w_nxt_state = SHOP;
    endcase
  end

  // List/count update and reject decision, same priority order.
  always_comb begin
    w_nxt_slots = r_slots;
    w_nxt_cnt   = r_cnt;
    w_rej       = 1'b0;
    if (r_state == SHOP) begin
      if (w_done_ev) begin
        w_rej = 1'b1;
      end else if (w_chk_ev) begin
        w_rej = w_is_empty;
      end else if (w_undo_ev) begin
        if (w_is_empty) begin
          w_rej = 1'b1;
        end else begin
          for (int k = 0; k < MAX_ITEMS; k++)
            if (4'(k) == r_cnt - 4'd1) w_nxt_slots[k] = '0;
          w_nxt_cnt = r_cnt - 4'd1;
        end
      end else if (w_add_ev) begin
        if (add_id == '0 || w_is_full) begin
          w_rej = 1'b1;
        end else begin
          for (int k = 0; k < MAX_ITEMS; k++)
            if (4'(k) == r_cnt) w_nxt_slots[k] = add_id;
          w_nxt_cnt = r_cnt + 4'd1;
        end
      end
    end else begin
      if (w_done_ev) begin
        w_nxt_slots = '0;
        w_nxt_cnt   = 4'd0;
      end else if (!w_chk_ev && (w_undo_ev || w_add_ev)) begin
        w_rej = 1'b1;
      end
    end
  end

  // Outputs
  always_comb begin
    product_IDS = r_slots;
    item_count  = r_cnt;
    empty       = r_empty;
    full        = r_full;
    locked      = (r_state == CHECKOUT);
    reject      = r_rej;
  end

endmodule

// File: tb/tb_cart_slot_buffer.sv
// Table-driven check of cart_slot_buffer: each vector is one clock; expected
// outputs are queued when the vector is driven and compared after the edge.
module tb_cart_slot_buffer;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        add_req = 1'b0, undo_req = 1'b0, checkout_req = 1'b0, done_req = 1'b0;
  logic [3:0]  add_id = 4'h0;
  logic [47:0] product_IDS;
  logic [3:0]  item_count;
  logic        empty, full, locked, reject;

  cart_slot_buffer dut (
    .CLK(CLK), .RST_N(RST_N), .add_req(add_req), .add_id(add_id),
    .undo_req(undo_req), .checkout_req(checkout_req), .done_req(done_req),
    .product_IDS(product_IDS), .item_count(item_count), .empty(empty),
    .full(full), .locked(locked), .reject(reject)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst_n, add, undo, chk, done;
    logic [3:0]  id;
    logic [47:0] ids;
    logic [3:0]  cnt;
    logic        locked, rej;
  } vec_t;

  typedef struct {
    logic [47:0] ids;
    logic [3:0]  cnt;
    logic        empty, full, locked, rej;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_step = 0;

  function automatic vec_t mk(input logic rst_n, input logic add, input logic [3:0] id,
                              input logic undo, input logic chk, input logic done,
                              input logic [47:0] ids, input logic [3:0] cnt,
                              input logic lck, input logic rej);
    vec_t v;
    v.rst_n = rst_n; v.add = add; v.id = id; v.undo = undo; v.chk = chk; v.done = done;
    v.ids = ids; v.cnt = cnt; v.locked = lck; v.rej = rej;
    return v;
  endfunction

  // Shorthand for a non-reset cycle.
  function automatic vec_t op(input logic add, input logic [3:0] id, input logic undo,
                              input logic chk, input logic done, input logic [47:0] ids,
                              input logic [3:0] cnt, input logic lck, input logic rej);
    return mk(1'b1, add, id, undo, chk, done, ids, cnt, lck, rej);
  endfunction

  task automatic step(input vec_t v, input string name);
    exp_t e;
    RST_N = v.rst_n; add_req = v.add; add_id = v.id;
    undo_req = v.undo; checkout_req = v.chk; done_req = v.done;
    e.ids = v.ids; e.cnt = v.cnt; e.empty = (v.cnt == 4'd0); e.full = (v.cnt == 4'd12);
    e.locked = v.locked; e.rej = v.rej;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    n_chk++;
    n_step++;
    if (product_IDS !== e.ids || item_count !== e.cnt || empty !== e.empty ||
        full !== e.full || locked !== e.locked || reject !== e.rej) begin
      n_fail++;
      $display("FAIL %s step%0d: got ids=%h cnt=%0d e=%b f=%b l=%b r=%b, want ids=%h cnt=%0d e=%b f=%b l=%b r=%b",
               name, n_step, product_IDS, item_count, empty, full, locked, reject,
               e.ids, e.cnt, e.empty, e.full, e.locked, e.rej);
    end
  endtask

  initial begin
    logic [47:0] a_all;
    logic [47:0] a_pat;
    a_all = 48'hAAAAAAAAAAAA;

    // add 3,7,5, undo down to empty and one more
    tbl.push_back(op(1,4'h3,0,0,0, 48'h300000000000, 1, 0, 0));
    tbl.push_back(op(0,4'h3,0,0,0, 48'h300000000000, 1, 0, 0));
    tbl.push_back(op(1,4'h7,0,0,0, 48'h370000000000, 2, 0, 0));
    tbl.push_back(op(0,4'h0,0,0,0, 48'h370000000000, 2, 0, 0));
    tbl.push_back(op(1,4'h5,0,0,0, 48'h375000000000, 3, 0, 0));
    tbl.push_back(op(0,4'h0,0,0,0, 48'h375000000000, 3, 0, 0));
    tbl.push_back(op(0,4'h0,1,0,0, 48'h370000000000, 2, 0, 0));
    tbl.push_back(op(0,4'h0,0,0,0, 48'h370000000000, 2, 0, 0));
    tbl.push_back(op(0,4'h0,1,0,0, 48'h300000000000, 1, 0, 0));
    tbl.push_back(op(0,4'h0,0,0,0, 48'h300000000000, 1, 0, 0));
    tbl.push_back(op(0,4'h0,1,0,0, 48'h0,            0, 0, 0));
    tbl.push_back(op(0,4'h0,0,0,0, 48'h0,            0, 0, 0));
    tbl.push_back(op(0,4'h0,1,0,0, 48'h0,            0, 0, 1));
    tbl.push_back(op(0,4'h0,0,0,0, 48'h0,            0, 0, 0));
    // add of ID 0, checkout on empty, done in SHOP
    tbl.push_back(op(1,4'h0,0,0,0, 48'h0,            0, 0, 1));
    tbl.push_back(op(0,4'h0,0,0,0, 48'h0,            0, 0, 0));
    tbl.push_back(op(0,4'h0,0,1,0, 48'h0,            0, 0, 1));
    tbl.push_back(op(0,4'h0,0,0,0, 48'h0,            0, 0, 0));
    tbl.push_back(op(0,4'h0,0,0,1, 48'h0,            0, 0, 1));
    tbl.push_back(op(0,4'h0,0,0,0, 48'h0,            0, 0, 0));
    // list 3,7 then checkout; add/undo refused, repeat checkout ignored, done clears
    tbl.push_back(op(1,4'h3,0,0,0, 48'h300000000000, 1, 0, 0));
    tbl.push_back(op(0,4'h0,0,0,0, 48'h300000000000, 1, 0, 0));
    tbl.push_back(op(1,4'h7,0,0,0, 48'h370000000000, 2, 0, 0));
    tbl.push_back(op(0,4'h0,0,0,0, 48'h370000000000, 2, 0, 0));
    tbl.push_back(op(0,4'h0,0,1,0, 48'h370000000000, 2, 1, 0));
    tbl.push_back(op(0,4'h0,0,0,0, 48'h370000000000, 2, 1, 0));
    tbl.push_back(op(1,4'h9,0,0,0, 48'h370000000000, 2, 1, 1));
    tbl.push_back(op(0,4'h0,0,0,0, 48'h370000000000, 2, 1, 0));
    tbl.push_back(op(0,4'h0,1,0,0, 48'h370000000000, 2, 1, 1));
    tbl.push_back(op(0,4'h0,0,0,0, 48'h370000000000, 2, 1, 0));
    tbl.push_back(op(0,4'h0,0,1,0, 48'h370000000000, 2, 1, 0));
    tbl.push_back(op(0,4'h0,0,0,0, 48'h370000000000, 2, 1, 0));
    tbl.push_back(op(0,4'h0,0,0,1, 48'h0,            0, 0, 0));
    tbl.push_back(op(0,4'h0,0,0,0, 48'h0,            0, 0, 0));
    // fill with twelve A's, then a 13th add is refused
    for (int i = 1; i <= 12; i++) begin
      a_pat = a_all & ~(48'hFFFFFFFFFFFF >> (4 * i));
      tbl.push_back(op(1,4'hA,0,0,0, a_pat, 4'(i), 0, 0));
      tbl.push_back(op(0,4'h0,0,0,0, a_pat, 4'(i), 0, 0));
    end
    tbl.push_back(op(1,4'h2,0,0,0, a_all, 12, 0, 1));
    tbl.push_back(op(0,4'h0,0,0,0, a_all, 12, 0, 0));
    // undo+add together: only undo acts
    tbl.push_back(op(1,4'h6,1,0,0, 48'hAAAAAAAAAAA0, 11, 0, 0));
    tbl.push_back(op(0,4'h0,0,0,0, 48'hAAAAAAAAAAA0, 11, 0, 0));
    // done+undo+add in SHOP: done wins and is refused, others dropped
    tbl.push_back(op(1,4'h6,1,0,1, 48'hAAAAAAAAAAA0, 11, 0, 1));
    tbl.push_back(op(0,4'h0,0,0,0, 48'hAAAAAAAAAAA0, 11, 0, 0));
    // checkout+undo: checkout wins
    tbl.push_back(op(0,4'h0,1,1,0, 48'hAAAAAAAAAAA0, 11, 1, 0));
    tbl.push_back(op(0,4'h0,0,0,0, 48'hAAAAAAAAAAA0, 11, 1, 0));
    tbl.push_back(op(0,4'h0,0,0,1, 48'h0,            0, 0, 0));
    tbl.push_back(op(0,4'h0,0,0,0, 48'h0,            0, 0, 0));
    // add held high for 10 cycles fills one slot
    tbl.push_back(op(1,4'h6,0,0,0, 48'h600000000000, 1, 0, 0));
    for (int i = 0; i < 9; i++)
      tbl.push_back(op(1,4'h6,0,0,0, 48'h600000000000, 1, 0, 0));
    tbl.push_back(op(0,4'h0,0,0,0, 48'h600000000000, 1, 0, 0));

    // reset state
    step(mk(0,0,4'h0,0,0,0, 48'h0, 0, 0, 0), "reset");
    step(mk(0,0,4'h0,0,0,0, 48'h0, 0, 0, 0), "reset");

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], "table");

    // reset mid-operation with add held; edge history clears, so it re-fires
    step(op(1,4'h4,0,0,0, 48'h640000000000, 2, 0, 0), "pre_rst");
    step(mk(0,1,4'h4,0,0,0, 48'h0, 0, 0, 0), "mid_rst");
    step(op(1,4'h4,0,0,0, 48'h400000000000, 1, 0, 0), "post_rst_edge");
    step(op(1,4'h4,0,0,0, 48'h400000000000, 1, 0, 0), "post_rst_hold");
    step(op(0,4'h0,0,0,0, 48'h400000000000, 1, 0, 0), "post_rst_idle");
    // reset while locked
    step(op(0,4'h0,0,1,0, 48'h400000000000, 1, 1, 0), "lock");
    step(mk(0,0,4'h0,0,1,0, 48'h0, 0, 0, 0), "rst_locked");
    step(op(0,4'h0,0,1,0, 48'h0, 0, 0, 1), "chk_after_rst");
    step(op(0,4'h0,0,0,0, 48'h0, 0, 0, 0), "final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
